// File: rtl/hidden_layer_collector_pkg.sv
// Shared constants and FSM encoding for the hidden-layer collector.
// Widths default to the activation ROM and inter-layer stream widths.
package hidden_layer_collector_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int ROM_BITWIDTH = 16;

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_DRAIN   = 1'b1;

  typedef enum logic {
    COLLECT = ST_COLLECT,
    DRAIN   = ST_DRAIN
  } state_t;

endpackage

// File: rtl/hidden_layer_collector.sv
// Gathers one activation per hidden neuron, then replays the vector
// as a serial valid/ready stream in neuron order.
module hidden_layer_collector
  import hidden_layer_collector_pkg::*;
#(
  parameter int numNeurons = 64,
  parameter int outWidth   = ROM_BITWIDTH,
  parameter int dataWidth  = DATA_WIDTH,
  parameter int idxWidth   = $clog2(numNeurons)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeurons*outWidth-1:0] neuron_out,
  input  logic [numNeurons-1:0]          neuron_valid,
  input  logic                           out_ready,
  input  logic                           clear_err,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [idxWidth-1:0]            out_idx,
  output logic                           busy,
  output logic                           overflow
);

  localparam logic [idxWidth-1:0] LAST_IDX =
    idxWidth'(numNeurons - 1);

  state_t                  state_q, state_d;
  logic [numNeurons-1:0]   got_q, got_d, cap;
  logic [idxWidth-1:0]     idx_q, idx_d;
  logic                    ovf_q, ovf_d, ovf_set;
  logic                    drain, at_last;
  logic [outWidth-1:0]     slot_q [numNeurons];

  assign drain   = (state_q == DRAIN);
  assign at_last = (idx_q == LAST_IDX);
  assign cap     = drain ? '0 : (neuron_valid & ~got_q);

  always_comb begin
    state_d = state_q;
    got_d   = got_q;
    idx_d   = idx_q;
    ovf_set = 1'b0;
    unique case (state_q)
      COLLECT: begin
        got_d   = got_q | neuron_valid;
        ovf_set = |(neuron_valid & got_q);
        if (&got_d) state_d = DRAIN;
      end
      DRAIN: begin
        ovf_set = |neuron_valid;
        if (out_ready) begin
          if (at_last) begin
            state_d = COLLECT;
            got_d   = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + idxWidth'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
    // a new error in the same cycle beats the clear
    ovf_d = ovf_set | (ovf_q & ~clear_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      got_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      got_q   <= got_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeurons; i++) begin
      if (cap[i]) slot_q[i] <= neuron_out[i*outWidth +: outWidth];
    end
  end

  always_comb begin
    out_data = '0;
    if (drain) out_data[outWidth-1:0] = slot_q[idx_q];
    out_valid = drain;
    out_last  = drain & at_last;
    out_idx   = idx_q;
    busy      = drain;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_hidden_layer_collector.sv
// Bench for hidden_layer_collector: table-driven vectors, a reset
// abort sequence and random traffic against a queue-based model.
module tb_hidden_layer_collector;

  localparam int N  = 64;
  localparam int OW = 16;
  localparam int DW = 16;
  localparam int IW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*OW-1:0] neuron_out;
  logic [N-1:0]    neuron_valid;
  logic            out_ready;
  logic            clear_err;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic [IW-1:0]   out_idx;
  logic            busy;
  logic            overflow;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] m_q[$];
  logic [N-1:0] m_got = '0;
  logic [15:0] m_val[N];
  bit m_ovf = 1'b0;

  int rdy_mode = 0;
  int cyc = 0;
  bit checking = 1'b0;
  bit clr_pending = 1'b0;

  typedef struct {
    int order;
    bit seq;
    int rdy;
    int dup;
    bit dp;
    bit exp_ovf;
  } vec_t;

  hidden_layer_collector dut (
    .clk(clk),
    .rst(rst),
    .neuron_out(neuron_out),
    .neuron_valid(neuron_valid),
    .out_ready(out_ready),
    .clear_err(clear_err),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_idx(out_idx),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: a vector becomes a queue of beats once every slot
  // has reported; the queue drains one entry per ready cycle.
  always @(posedge clk) begin
    if (rst) begin
      bit set_ev;
      set_ev = 1'b0;
      if (m_q.size() != 0) begin
        set_ev = |neuron_valid;
        if (out_ready) void'(m_q.pop_front());
      end else begin
        for (int i = 0; i < N; i++) begin
          if (neuron_valid[i]) begin
            if (m_got[i]) set_ev = 1'b1;
            else begin
              m_got[i] = 1'b1;
              m_val[i] = neuron_out[i*OW +: OW];
            end
          end
        end
        if (&m_got) begin
          for (int i = 0; i < N; i++) m_q.push_back(m_val[i]);
          m_got = '0;
        end
      end
      m_ovf = set_ev | (m_ovf & !clear_err);
    end
  end

  always @(negedge rst) begin
    m_q.delete();
    m_got = '0;
    m_ovf = 1'b0;
  end

  always @(negedge clk) begin
    if (checking) begin
      int sz;
      logic [25:0] exp_v, act_v;
      logic [IW-1:0] e_idx;
      logic [15:0] e_dat;
      sz = m_q.size();
      e_idx = (sz != 0) ? IW'(N - sz) : '0;
      e_dat = (sz != 0) ? m_q[0] : '0;
      exp_v = {sz != 0, sz == 1, sz != 0, m_ovf, e_idx, e_dat};
      act_v = {out_valid, out_last, busy, overflow, out_idx, out_data};
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL cycle t=%0t got v%0b l%0b b%0b o%0b i%0d d%h want v%0b l%0b b%0b o%0b i%0d d%h",
          $time, out_valid, out_last, busy, overflow, out_idx, out_data,
          sz != 0, sz == 1, sz != 0, m_ovf, e_idx, e_dat);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (clr_pending) begin
      clr_pending = 1'b0;
      clear_err = 1'b0;
      cmp("ovf_cleared", 32'(overflow), 32'd0);
    end
  endtask

  task automatic drive_vec(input int order, input bit seq, input int dup);
    logic [15:0] v[N];
    for (int i = 0; i < N; i++) v[i] = seq ? 16'(i + 1) : 16'($urandom);
    if (dup >= 0) begin
      v[dup] = 16'h000B;
      neuron_valid = '0;
      neuron_valid[dup] = 1'b1;
      neuron_out[dup*OW +: OW] = 16'h000A;
      step();
    end
    if (order == 0) begin
      for (int i = 0; i < N; i++) neuron_out[i*OW +: OW] = v[i];
      neuron_valid = '1;
      step();
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        neuron_valid = '0;
        neuron_valid[i] = 1'b1;
        neuron_out[i*OW +: OW] = v[i];
        step();
      end
    end
    neuron_valid = '0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (m_q.size() != 0 && c < 3000) begin
      step();
      c++;
    end
    if (m_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d beats left want 0", m_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    logic [N-1:0] sent, nv;
    int c;

    tbl[0] = '{0, 1'b1, 0, -1, 1'b0, 1'b0};
    tbl[1] = '{1, 1'b0, 0, -1, 1'b0, 1'b0};
    tbl[2] = '{0, 1'b0, 1, -1, 1'b0, 1'b0};
    tbl[3] = '{1, 1'b0, 0,  5, 1'b0, 1'b1};
    tbl[4] = '{0, 1'b1, 0, -1, 1'b1, 1'b1};
    tbl[5] = '{0, 1'b0, 2, -1, 1'b0, 1'b0};

    rst = 1'b0;
    neuron_valid = '0;
    neuron_out = '0;
    out_ready = 1'b1;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state",
        32'({out_valid, out_last, busy, overflow, out_idx, out_data}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    checking = 1'b1;
    @(posedge clk);
    #1;

    for (int e = 0; e < 6; e++) begin
      rdy_mode = tbl[e].rdy;
      clear_err = 1'b1;
      clr_pending = 1'b1;
      drive_vec(tbl[e].order, tbl[e].seq, tbl[e].dup);
      if (tbl[e].dp) begin
        step();
        step();
        neuron_valid = {$urandom, $urandom} | 64'd1;
        for (int i = 0; i < N; i++) neuron_out[i*OW +: OW] = 16'($urandom);
        clear_err = 1'b1;
        step();
        neuron_valid = '0;
        clear_err = 1'b0;
      end
      wait_drain();
      cmp($sformatf("ovf_entry%0d", e), 32'(overflow), 32'(tbl[e].exp_ovf));
    end

    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    rdy_mode = 0;
    drive_vec(0, 1'b1, -1);
    step();
    neuron_valid[3] = 1'b1;
    step();
    neuron_valid = '0;
    c = 0;
    while (m_q.size() != 44 && c < 200) begin
      step();
      c++;
    end
    cmp("idx_before_rst", 32'(out_idx), 32'd20);
    #1;
    rst = 1'b0;
    #1;
    cmp("rst_async_flags",
        32'({out_valid, busy, out_last, overflow}), 32'd0);
    cmp("rst_async_idx", 32'(out_idx), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 2;
    drive_vec(0, 1'b0, -1);
    wait_drain();

    for (int r = 0; r < 6; r++) begin
      rdy_mode = 2;
      sent = '0;
      c = 0;
      while (sent != '1) begin
        nv = {$urandom, $urandom} & {$urandom, $urandom}
           & {$urandom, $urandom};
        if (c >= 40) nv = nv | ~sent;
        for (int i = 0; i < N; i++) neuron_out[i*OW +: OW] = 16'($urandom);
        neuron_valid = nv;
        step();
        sent = sent | nv;
        c++;
      end
      neuron_valid = '0;
      wait_drain();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
